lfsr_burst_gen: RTL and testbench

- Parametrised Galois LFSR pseudo-random generator. Generalises the fixed 8-bit seeded LFSR to any width and tap polynomial.
- Adds continuous and counted-burst stepping modes, lockup protection, and a holdable output snapshot register.
- Sits behind the chip-level io_in/io_out wrapper; drives the output bus directly or feeds downstream test-pattern logic.

---
 rtl/lfsr_burst_gen.sv | 190 +++++++++++++++++++
 tb/tb_lfsr_burst_gen.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_burst_gen.sv
// lfsr_burst_gen: parametrised Galois LFSR with free-running and counted-burst
// stepping, zero-seed lockup protection and a holdable output snapshot.
//
// Ports:
//   i_clock        single clock, rising edge
//   i_reset        synchronous active-high reset
//   i_seed_load    load i_seed_in (zero is replaced by SEED); aborts any burst
//   i_seed_in      seed value
//   i_run          step continuously while high (FREE)
//   i_burst_start  start a burst of i_burst_len steps
//   i_burst_len    burst step count
//   i_hold         freeze o_rand_out
//   o_rand_out     snapshot of the state, one cycle behind
//   o_bit_out      state[0]
//   o_busy         high while a burst is running
//   o_burst_done   one-cycle pulse after the final burst step
//   o_lockup       one-cycle pulse after a zero seed was replaced
//   o_period_len   (LFSR_PERIOD_CNT_EN) last measured period in steps
//   o_period_hit   (LFSR_PERIOD_CNT_EN) pulse when the state returns to the seed
//
// Optional feature macro: LFSR_PERIOD_CNT_EN
//
// state   | meaning
// S_IDLE  | state holds; waits for burst_start or run
// S_FREE  | one step per cycle while run stays high
// S_BURST | one step per cycle until the burst counter expires
module lfsr_burst_gen #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01,
  parameter int               CNT_W = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_seed_load,
  input  logic [WIDTH-1:0] i_seed_in,
  input  logic             i_run,
  input  logic             i_burst_start,
  input  logic [CNT_W-1:0] i_burst_len,
  input  logic             i_hold,
  output logic [WIDTH-1:0] o_rand_out,
  output logic             o_bit_out,
  output logic             o_busy,
  output logic             o_burst_done,
`ifdef LFSR_PERIOD_CNT_EN
  output logic [WIDTH-1:0] o_period_len,
  output logic             o_period_hit,
`endif
  output logic             o_lockup
);

  typedef enum logic [1:0] {S_IDLE, S_FREE, S_BURST} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_fsm;
  state_t           w_fsm_nxt;
  logic [WIDTH-1:0] r_lfsr;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_rand;
  logic             r_done;
  logic             r_lockup;
  logic             w_step;
  logic             w_done_nxt;
  logic [WIDTH-1:0] w_lfsr_step;
  logic [WIDTH-1:0] w_seed_eff;

  assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);
  // A zero state would lock the LFSR forever, so substitute SEED.
  assign w_seed_eff  = (i_seed_in == '0) ? SEED : i_seed_in;

  always_comb begin
    w_fsm_nxt  = r_fsm;
    w_cnt_nxt  = r_cnt;
    w_step     = 1'b0;
    w_done_nxt = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        if (i_burst_start) begin
          if (i_burst_len != '0) begin
            w_fsm_nxt = S_BURST;
            w_cnt_nxt = i_burst_len;
          end else begin
            w_done_nxt = 1'b1;
          end
        end else if (i_run) begin
          w_fsm_nxt = S_FREE;
        end
      end
      S_FREE: begin
        if (i_burst_start) begin
          if (i_burst_len != '0) begin
            w_fsm_nxt = S_BURST;
            w_cnt_nxt = i_burst_len;
          end else begin
            w_fsm_nxt  = S_IDLE;
            w_done_nxt = 1'b1;
          end
        end else if (i_run) begin
          w_step = 1'b1;
        end else begin
          w_fsm_nxt = S_IDLE;
        end
      end
      S_BURST: begin
        w_step = 1'b1;
        // <= also covers a zero count, so the counter can never underflow.
        if (r_cnt <= CNT_ONE) begin
          w_cnt_nxt  = '0;
          w_fsm_nxt  = S_IDLE;
          w_done_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_fsm    <= S_IDLE;
      r_lfsr   <= SEED;
      r_cnt    <= '0;
      r_rand   <= '0;
      r_done   <= 1'b0;
      r_lockup <= 1'b0;
    end else begin
      if (!i_hold) r_rand <= r_lfsr;
      if (i_seed_load) begin
        r_fsm    <= S_IDLE;
        r_lfsr   <= w_seed_eff;
        r_cnt    <= '0;
        r_done   <= 1'b0;
        r_lockup <= (i_seed_in == '0);
      end else begin
        r_fsm    <= w_fsm_nxt;
        r_cnt    <= w_cnt_nxt;
        r_done   <= w_done_nxt;
        r_lockup <= 1'b0;
        if (w_step) r_lfsr <= w_lfsr_step;
      end
    end
  end

  assign o_rand_out   = r_rand;
  assign o_bit_out    = r_lfsr[0];
  assign o_busy       = (r_fsm == S_BURST);
  assign o_burst_done = r_done;
  assign o_lockup     = r_lockup;

`ifdef LFSR_PERIOD_CNT_EN
  localparam logic [WIDTH-1:0] PCNT_ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_pcnt;
  logic [WIDTH-1:0] r_seed_copy;
  logic [WIDTH-1:0] r_period_len;
  logic             r_period_hit;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_pcnt       <= '0;
      r_seed_copy  <= SEED;
      r_period_len <= '0;
      r_period_hit <= 1'b0;
    end else if (i_seed_load) begin
      r_pcnt       <= '0;
      r_seed_copy  <= w_seed_eff;
      r_period_hit <= 1'b0;
    end else begin
      r_period_hit <= 1'b0;
      if (w_step) begin
        // Count includes the step that lands back on the seed.
        if (w_lfsr_step == r_seed_copy) begin
          r_period_hit <= 1'b1;
          r_period_len <= r_pcnt + PCNT_ONE;
          r_pcnt       <= '0;
        end else begin
          r_pcnt <= r_pcnt + PCNT_ONE;
        end
      end
    end
  end

  assign o_period_len = r_period_len;
  assign o_period_hit = r_period_hit;
`endif

endmodule

// File: tb/tb_lfsr_burst_gen.sv
module tb_lfsr_burst_gen;

  localparam logic [7:0] TAPS = 8'hB8;
  localparam logic [7:0] SEED = 8'h01;
  localparam int M_IDLE  = 0;
  localparam int M_FREE  = 1;
  localparam int M_BURST = 2;

  logic       i_clock = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_seed_load = 1'b0;
  logic [7:0] i_seed_in = 8'h00;
  logic       i_run = 1'b0;
  logic       i_burst_start = 1'b0;
  logic [7:0] i_burst_len = 8'h00;
  logic       i_hold = 1'b0;
  logic [7:0] o_rand_out;
  logic       o_bit_out;
  logic       o_busy;
  logic       o_burst_done;
  logic       o_lockup;
`ifdef LFSR_PERIOD_CNT_EN
  logic [7:0] o_period_len;
  logic       o_period_hit;
`endif

  lfsr_burst_gen dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_seed_load   (i_seed_load),
    .i_seed_in     (i_seed_in),
    .i_run         (i_run),
    .i_burst_start (i_burst_start),
    .i_burst_len   (i_burst_len),
    .i_hold        (i_hold),
    .o_rand_out    (o_rand_out),
    .o_bit_out     (o_bit_out),
    .o_busy        (o_busy),
    .o_burst_done  (o_burst_done),
`ifdef LFSR_PERIOD_CNT_EN
    .o_period_len  (o_period_len),
    .o_period_hit  (o_period_hit),
`endif
    .o_lockup      (o_lockup)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [7:0] rnd;
    logic       bit0;
    logic       busy;
    logic       done;
    logic       lock;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Behavioural reference: LFSR value, operating mode and steps left in a burst.
  logic [7:0] m_s;
  int         m_mode;
  int         m_rem;
  logic [7:0] m_rand;
  logic       m_done;
  logic       m_lock;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : 8'h00);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, advance the model, queue the expected outputs,
  // then return shortly after the edge so directed checks see the new outputs.
  task automatic cyc(input logic rst, input logic sl, input logic [7:0] seed,
                     input logic run, input logic bs, input logic [7:0] len,
                     input logic hold);
    exp_t e;
    @(negedge i_clock);
    i_reset = rst; i_seed_load = sl; i_seed_in = seed; i_run = run;
    i_burst_start = bs; i_burst_len = len; i_hold = hold;
    if (rst) begin
      m_s = SEED; m_mode = M_IDLE; m_rem = 0; m_rand = 8'h00; m_done = 1'b0; m_lock = 1'b0;
    end else begin
      if (!hold) m_rand = m_s;
      m_done = 1'b0;
      m_lock = 1'b0;
      if (sl) begin
        m_s = (seed == 8'h00) ? SEED : seed;
        m_lock = (seed == 8'h00);
        m_mode = M_IDLE;
        m_rem = 0;
      end else if (m_mode != M_BURST && bs) begin
        if (len == 8'h00) begin
          m_done = 1'b1;
          m_mode = M_IDLE;
        end else begin
          m_mode = M_BURST;
          m_rem = int'(len);
        end
      end else if (m_mode == M_BURST) begin
        m_s = lfsr_next(m_s);
        m_rem--;
        if (m_rem == 0) begin
          m_mode = M_IDLE;
          m_done = 1'b1;
        end
      end else if (run) begin
        if (m_mode == M_FREE) m_s = lfsr_next(m_s);
        m_mode = M_FREE;
      end else begin
        m_mode = M_IDLE;
      end
    end
    e.rnd = m_rand; e.bit0 = m_s[0]; e.busy = (m_mode == M_BURST);
    e.done = m_done; e.lock = m_lock;
    q.push_back(e);
    @(posedge i_clock);
    #2;
  endtask

  task automatic idle1();
    cyc(0, 0, 8'h00, 0, 0, 8'h00, 0);
  endtask

  // Monitor: the DUT presents a full output vector every cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge i_clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb_rand_out", o_rand_out, e.rnd);
        chk("sb_bit_out", o_bit_out, e.bit0);
        chk("sb_busy", o_busy, e.busy);
        chk("sb_burst_done", o_burst_done, e.done);
        chk("sb_lockup", o_lockup, e.lock);
      end
    end
  end

  initial begin
    logic [7:0] seq [6];
    logic [7:0] frozen;
    int busy_cnt;
    int done_seen;
    seq = '{8'h01, 8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17};

    // Reset
    cyc(1, 0, 8'h00, 0, 0, 8'h00, 0);
    cyc(1, 0, 8'h00, 1, 0, 8'h00, 0);
    chk("reset_rand", o_rand_out, 8'h00);
    chk("reset_busy", o_busy, 1'b0);
    chk("reset_done", o_burst_done, 1'b0);
    chk("reset_lockup", o_lockup, 1'b0);
    chk("reset_bit", o_bit_out, 1'b1);

    // Free run from seed 01
    cyc(0, 1, 8'h01, 0, 0, 8'h00, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 8'h00, 1, 0, 8'h00, 0);
      chk("run_rand_seq", o_rand_out, seq[i]);
    end
    idle1();
    chk("run_last_rand", o_rand_out, 8'hB3);

    // Zero seed triggers lockup recovery
    cyc(0, 1, 8'h00, 0, 0, 8'h00, 0);
    chk("zero_seed_lockup", o_lockup, 1'b1);
    chk("zero_seed_bit", o_bit_out, 1'b1);
    idle1();
    chk("lockup_one_cycle", o_lockup, 1'b0);
    idle1();
    chk("zero_seed_state", o_rand_out, 8'h01);

    // Burst of 4 with run asserted mid-burst
    cyc(0, 0, 8'h00, 0, 1, 8'd4, 0);
    busy_cnt = o_busy ? 1 : 0;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 8'h00, 1, 0, 8'h00, 0);
      if (o_burst_done) begin
        done_seen = 1;
        break;
      end
      if (o_busy) busy_cnt++;
    end
    chk("burst4_done_seen", done_seen, 1);
    chk("burst4_busy_cycles", busy_cnt, 4);
    chk("burst4_busy_low_at_done", o_busy, 1'b0);
    idle1();
    chk("burst4_final_state", o_rand_out, 8'h17);
    chk("burst4_done_one_cycle", o_burst_done, 1'b0);

    // Abort a burst with seed_load, then a zero-length burst
    cyc(0, 0, 8'h00, 0, 1, 8'd5, 0);
    idle1();
    idle1();
    cyc(0, 1, 8'h5A, 0, 0, 8'h00, 0);
    chk("abort_busy", o_busy, 1'b0);
    chk("abort_no_done", o_burst_done, 1'b0);
    chk("abort_no_lockup", o_lockup, 1'b0);
    idle1();
    chk("abort_no_done_later", o_burst_done, 1'b0);
    chk("abort_state", o_rand_out, 8'h5A);
    cyc(0, 0, 8'h00, 0, 1, 8'd0, 0);
    chk("len0_done", o_burst_done, 1'b1);
    chk("len0_busy", o_busy, 1'b0);
    idle1();
    chk("len0_done_pulse", o_burst_done, 1'b0);
    chk("len0_state", o_rand_out, 8'h5A);

    // Hold while running, then reset mid-run
    cyc(0, 0, 8'h00, 1, 0, 8'h00, 0);
    cyc(0, 0, 8'h00, 1, 0, 8'h00, 0);
    frozen = m_rand;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 8'h00, 1, 0, 8'h00, 1);
      chk("hold_frozen", o_rand_out, frozen);
    end
    cyc(1, 0, 8'h00, 1, 0, 8'h00, 0);
    chk("midrun_reset_rand", o_rand_out, 8'h00);
    chk("midrun_reset_busy", o_busy, 1'b0);
    chk("midrun_reset_bit", o_bit_out, 1'b1);

`ifdef LFSR_PERIOD_CNT_EN
    begin
      int hits = 0;
      cyc(0, 1, 8'h01, 0, 0, 8'h00, 0);
      for (int i = 0; i < 256; i++) begin
        cyc(0, 0, 8'h00, 1, 0, 8'h00, 0);
        if (o_period_hit) hits++;
      end
      idle1();
      chk("period_hits", hits, 1);
      chk("period_len", o_period_len, 8'd255);
    end
`endif

    // Randomised traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      logic rst, sl, run, bs, hold;
      logic [7:0] seed, len;
      rst  = ($urandom_range(0, 199) == 0);
      sl   = ($urandom_range(0, 29) == 0);
      seed = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      run  = ($urandom_range(0, 9) < 6);
      bs   = ($urandom_range(0, 7) == 0);
      len  = ($urandom_range(0, 19) == 0) ? 8'hFF : 8'($urandom_range(0, 12));
      hold = ($urandom_range(0, 3) == 0);
      cyc(rst, sl, seed, run, bs, len, hold);
    end

    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
